// File: rtl/uc_multiciclo_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// decoded instruction classes, opcodes, ALU op codes and address-mux encodings.
package uc_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM_PTR,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_BAD,
    CL_ALU,
    CL_LDI,
    CL_LD_DIR,
    CL_LD_IND,
    CL_LD_REG,
    CL_LD_REL,
    CL_JMP,
    CL_JREL,
    CL_JZ,
    CL_JNZ
  } cls_t;

  typedef enum logic [1:0] {
    SA_IMM     = 2'd0,
    SA_MEM     = 2'd1,
    SA_REG     = 2'd2,
    SA_REG_IMM = 2'd3
  } s_addr_t;

  localparam logic [7:0] OP_LDI    = 8'h10;
  localparam logic [7:0] OP_LD_DIR = 8'h11;
  localparam logic [7:0] OP_LD_IND = 8'h12;
  localparam logic [7:0] OP_LD_REG = 8'h13;
  localparam logic [7:0] OP_LD_REL = 8'h14;
  localparam logic [7:0] OP_JMP    = 8'h15;
  localparam logic [7:0] OP_JREL   = 8'h16;
  localparam logic [7:0] OP_JZ     = 8'h17;
  localparam logic [7:0] OP_JNZ    = 8'h18;

  // ALU codes that the immediate class remaps; the rest pass through unchanged.
  localparam logic [2:0] ALU_PASS  = 3'b000;
  localparam logic [2:0] ALU_OP_1  = 3'b001;
  localparam logic [2:0] ALU_OP_6  = 3'b110;

  // Datapath strobes driven by the FSM (op_alu is width-parameterised, kept apart).
  typedef struct packed {
    logic    we_ir;
    logic    we_pc;
    logic    s_inc;
    logic    s_rel_pc;
    logic    s_inm;
    logic    s_datos;
    s_addr_t s_addr;
    logic    mem_re;
    logic    we3;
    logic    wez;
  } ctrl_t;

  function automatic s_addr_t addr_mode(input cls_t cls);
    case (cls)
      CL_LD_IND: addr_mode = SA_MEM;
      CL_LD_REG: addr_mode = SA_REG;
      CL_LD_REL: addr_mode = SA_REG_IMM;
      default:   addr_mode = SA_IMM;
    endcase
  endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control-unit bus: instruction/status inputs and datapath strobes.
// The trap line exists only when UC_TRAP_EN is defined.
interface uc_multiciclo_if #(
  parameter int OPCODE_W = 8,
  parameter int ALU_OP_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                z;
  logic                mem_ready;
  logic                we_ir;
  logic                we_pc;
  logic                s_inc;
  logic                s_rel_pc;
  logic                s_inm;
  logic                s_datos;
  logic [1:0]          s_addr;
  logic                mem_re;
  logic                we3;
  logic                wez;
  logic [ALU_OP_W-1:0] op_alu;
  logic                mem_err;
`ifdef UC_TRAP_EN
  logic                trap;
`endif

  modport master (
    input  opcode, z, mem_ready,
    output we_ir, we_pc, s_inc, s_rel_pc, s_inm, s_datos, s_addr,
           mem_re, we3, wez, op_alu, mem_err
`ifdef UC_TRAP_EN
    , output trap
`endif
  );

  modport slave (
    output opcode, z, mem_ready,
    input  we_ir, we_pc, s_inc, s_rel_pc, s_inm, s_datos, s_addr,
           mem_re, we3, wez, op_alu, mem_err
`ifdef UC_TRAP_EN
    , input trap
`endif
  );

endinterface

// File: rtl/uc_multiciclo_alu_dec.sv
// Combinational opcode decoder: instruction class, ALU operation and
// immediate-operand select.
module uc_alu_dec
  import uc_pkg::*;
#(
  parameter int OPCODE_W = 8,
  parameter int ALU_OP_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output cls_t                cls_o,
  output logic [ALU_OP_W-1:0] op_alu_o,
  output logic                s_inm_o
);

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    cls_o    = CL_BAD;
    op_alu_o = '0;
    s_inm_o  = 1'b0;
    if (opcode_i[OPCODE_W-1]) begin
      cls_o    = CL_ALU;
      op_alu_o = opcode_i[OPCODE_W-2 -: ALU_OP_W];
    end else if (opcode_i[OPCODE_W-2:4] == '0) begin
      // Immediate ALU ops: codes 2..5 pass through, 0/6/7 are remapped, 1 is unused.
      cls_o   = CL_ALU;
      s_inm_o = 1'b1;
      case (opcode_i[3:0])
        4'h0:                   op_alu_o = ALU_OP_W'(ALU_PASS);
        4'h2, 4'h3, 4'h4, 4'h5: op_alu_o = ALU_OP_W'(opcode_i[2:0]);
        4'h6:                   op_alu_o = ALU_OP_W'(ALU_OP_1);
        4'h7:                   op_alu_o = ALU_OP_W'(ALU_OP_6);
        default: begin
          cls_o   = CL_BAD;
          s_inm_o = 1'b0;
        end
      endcase
    end else begin
      case (opcode_i)
        OPCODE_W'(OP_LDI): begin
          cls_o   = CL_LDI;
          s_inm_o = 1'b1;
        end
        OPCODE_W'(OP_LD_DIR): cls_o = CL_LD_DIR;
        OPCODE_W'(OP_LD_IND): cls_o = CL_LD_IND;
        OPCODE_W'(OP_LD_REG): cls_o = CL_LD_REG;
        OPCODE_W'(OP_LD_REL): cls_o = CL_LD_REL;
        OPCODE_W'(OP_JMP):    cls_o = CL_JMP;
        OPCODE_W'(OP_JREL):   cls_o = CL_JREL;
        OPCODE_W'(OP_JZ):     cls_o = CL_JZ;
        OPCODE_W'(OP_JNZ):    cls_o = CL_JNZ;
        default:              cls_o = CL_BAD;
      endcase
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready
// wait counter and sticky timeout flag. Define UC_TRAP_EN to trap on bad opcodes.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int OPCODE_W = 8,
  parameter int ALU_OP_W = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  uc_multiciclo_if.master bus
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t              state_q, state_d;
  cls_t                cls_q, cls_d, dec_cls;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d, dec_op;
  logic                inm_q, inm_d, dec_inm;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                in_mem, timeout;
  ctrl_t               ctrl;
  logic [ALU_OP_W-1:0] op_alu;
`ifdef UC_TRAP_EN
  logic                trap;
`endif

  uc_alu_dec #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_dec (
    .opcode_i (bus.opcode),
    .cls_o    (dec_cls),
    .op_alu_o (dec_op),
    .s_inm_o  (dec_inm)
  );

  assign in_mem  = (state_q == MEM_PTR) || (state_q == MEM);
  // A ready arriving on the last allowed cycle wins over the timeout.
  assign timeout = in_mem && !bus.mem_ready && (cnt_q == CNT_W'(WAIT_MAX));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      cls_q    <= CL_BAD;
      alu_op_q <= '0;
      inm_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      alu_op_q <= alu_op_d;
      inm_q    <= inm_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    alu_op_d = alu_op_q;
    inm_d    = inm_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        cls_d    = dec_cls;
        alu_op_d = dec_op;
        inm_d    = dec_inm;
        cnt_d    = '0;
        case (dec_cls)
          CL_LD_IND:                      state_d = MEM_PTR;
          CL_LD_DIR, CL_LD_REG, CL_LD_REL: state_d = MEM;
`ifdef UC_TRAP_EN
          CL_BAD:                         state_d = TRAP;
`endif
          default:                        state_d = EXEC;
        endcase
      end
      EXEC: state_d = FETCH;
      MEM_PTR, MEM: begin
        if (bus.mem_ready) begin
          state_d = (state_q == MEM_PTR) ? MEM : WB;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = FETCH;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ctrl   = '0;
    op_alu = '0;
`ifdef UC_TRAP_EN
    trap   = 1'b0;
`endif
    case (state_q)
      FETCH: ctrl.we_ir = 1'b1;
      EXEC: begin
        op_alu     = alu_op_q;
        ctrl.s_inm = inm_q;
        ctrl.we_pc = 1'b1;
        ctrl.s_inc = 1'b1;
        case (cls_q)
          CL_ALU: begin
            ctrl.we3 = 1'b1;
            ctrl.wez = 1'b1;
          end
          CL_LDI:  ctrl.we3      = 1'b1;
          CL_JMP:  ctrl.s_inc    = 1'b0;
          CL_JREL: ctrl.s_rel_pc = 1'b1;
          CL_JZ:   ctrl.s_inc    = ~bus.z;
          CL_JNZ:  ctrl.s_inc    = bus.z;
          default: ;
        endcase
      end
      MEM_PTR: begin
        ctrl.mem_re = 1'b1;
        ctrl.s_addr = SA_IMM;
      end
      MEM: begin
        ctrl.mem_re = 1'b1;
        ctrl.s_addr = addr_mode(cls_q);
      end
      WB: begin
        ctrl.s_datos = 1'b1;
        ctrl.we3     = 1'b1;
        ctrl.we_pc   = 1'b1;
        ctrl.s_inc   = 1'b1;
      end
`ifdef UC_TRAP_EN
      TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
    // Timed-out load skips the instruction: advance PC, no register write.
    if (timeout) begin
      ctrl.we_pc = 1'b1;
      ctrl.s_inc = 1'b1;
    end
    // Reset abandons the instruction at once, so no strobe leaks in the reset cycle.
    if (!reset_n) begin
      ctrl   = '0;
      op_alu = '0;
`ifdef UC_TRAP_EN
      trap   = 1'b0;
`endif
    end
  end

  assign bus.we_ir    = ctrl.we_ir;
  assign bus.we_pc    = ctrl.we_pc;
  assign bus.s_inc    = ctrl.s_inc;
  assign bus.s_rel_pc = ctrl.s_rel_pc;
  assign bus.s_inm    = ctrl.s_inm;
  assign bus.s_datos  = ctrl.s_datos;
  assign bus.s_addr   = ctrl.s_addr;
  assign bus.mem_re   = ctrl.mem_re;
  assign bus.we3      = ctrl.we3;
  assign bus.wez      = ctrl.wez;
  assign bus.op_alu   = op_alu;
  assign bus.mem_err  = err_q;
`ifdef UC_TRAP_EN
  assign bus.trap     = trap;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: per-cycle strobe vectors checked against
// hand-computed expectations for ALU, jump, load, timeout, reset and bad-opcode cases.
module tb_uc_multiciclo;

  localparam int OPCODE_W = 8;
  localparam int ALU_OP_W = 3;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  uc_multiciclo_if #(.OPCODE_W(OPCODE_W), .ALU_OP_W(ALU_OP_W)) bus ();

  uc_multiciclo #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Packs {we_ir,we_pc,s_inc,s_rel_pc,s_inm,s_datos,s_addr,mem_re,we3,wez,op_alu}.
  function automatic logic [13:0] ex(input logic we_ir, we_pc, s_inc, s_rel, s_inm, s_datos,
                                     input logic [1:0] s_addr, input logic mem_re, we3, wez,
                                     input logic [2:0] op);
    return {we_ir, we_pc, s_inc, s_rel, s_inm, s_datos, s_addr, mem_re, we3, wez, op};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.we_ir, bus.we_pc, bus.s_inc, bus.s_rel_pc, bus.s_inm, bus.s_datos,
            bus.s_addr, bus.mem_re, bus.we3, bus.wez, bus.op_alu};
  endfunction

  // Drive inputs for the current cycle, check the strobes, advance one clock.
  task automatic step(input string tag, input logic [7:0] op, input logic z, input logic rdy,
                      input logic [13:0] want);
    bus.opcode    = op;
    bus.z         = z;
    bus.mem_ready = rdy;
    #1;
    check(tag, 32'(observed()), 32'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic run_short(input string tag, input logic [7:0] op, input logic z,
                           input logic [13:0] want_exec);
    step({tag, "_fetch"}, op, z, 1'b0, ex(1,0,0,0,0,0,2'd0,0,0,0,3'd0));
    step({tag, "_decode"}, op, z, 1'b0, '0);
    step({tag, "_exec"}, op, z, 1'b0, want_exec);
  endtask

  localparam logic [13:0] S_FETCH = 14'b1_0000_0000_0000_0;

  initial begin
    reset_n       = 1'b0;
    bus.opcode    = '0;
    bus.z         = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("rst_strobes", 8'hA5, 1'b1, 1'b1, '0);
    check("rst_mem_err", 32'(bus.mem_err), 32'd0);
    reset_n = 1'b1;

    // Register/immediate ALU, load-immediate and jumps (3 cycles each).
    run_short("alu_reg_a5", 8'hA5, 1'b0, ex(0,1,1,0,0,0,2'd0,0,1,1,3'b010));
    run_short("alu_imm_06", 8'h06, 1'b0, ex(0,1,1,0,1,0,2'd0,0,1,1,3'b001));
    run_short("alu_imm_07", 8'h07, 1'b0, ex(0,1,1,0,1,0,2'd0,0,1,1,3'b110));
    run_short("alu_imm_03", 8'h03, 1'b0, ex(0,1,1,0,1,0,2'd0,0,1,1,3'b011));
    run_short("ldi_10",     8'h10, 1'b0, ex(0,1,1,0,1,0,2'd0,0,1,0,3'b000));
    run_short("jz_z1",      8'h17, 1'b1, ex(0,1,0,0,0,0,2'd0,0,0,0,3'd0));
    run_short("jz_z0",      8'h17, 1'b0, ex(0,1,1,0,0,0,2'd0,0,0,0,3'd0));
    run_short("jnz_z0",     8'h18, 1'b0, ex(0,1,0,0,0,0,2'd0,0,0,0,3'd0));
    run_short("jnz_z1",     8'h18, 1'b1, ex(0,1,1,0,0,0,2'd0,0,0,0,3'd0));
    run_short("jmp_15",     8'h15, 1'b1, ex(0,1,0,0,0,0,2'd0,0,0,0,3'd0));
    run_short("jrel_16",    8'h16, 1'b0, ex(0,1,1,1,0,0,2'd0,0,0,0,3'd0));

    // Indirect load, two wait cycles per access; opcode change mid-MEM must be ignored.
    step("ind_fetch",  8'h12, 1'b0, 1'b0, S_FETCH);
    step("ind_decode", 8'h12, 1'b0, 1'b0, '0);
    step("ind_ptr_w1", 8'h12, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'd0,1,0,0,3'd0));
    step("ind_ptr_w2", 8'h12, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'd0,1,0,0,3'd0));
    step("ind_ptr_rd", 8'h12, 1'b0, 1'b1, ex(0,0,0,0,0,0,2'd0,1,0,0,3'd0));
    step("ind_mem_w1", 8'h12, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'd1,1,0,0,3'd0));
    step("ind_mem_w2", 8'h13, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'd1,1,0,0,3'd0));
    step("ind_mem_rd", 8'hA5, 1'b0, 1'b1, ex(0,0,0,0,0,0,2'd1,1,0,0,3'd0));
    step("ind_wb",     8'hA5, 1'b0, 1'b0, ex(0,1,1,0,0,1,2'd0,0,1,0,3'd0));

    // Register load with ready on the very last allowed wait cycle: not a timeout.
    step("reg_fetch",  8'h13, 1'b0, 1'b0, S_FETCH);
    step("reg_decode", 8'h13, 1'b0, 1'b0, '0);
    for (int i = 0; i < WAIT_MAX; i++)
      step("reg_wait", 8'h13, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'd2,1,0,0,3'd0));
    step("reg_late_rd", 8'h13, 1'b0, 1'b1, ex(0,0,0,0,0,0,2'd2,1,0,0,3'd0));
    step("reg_wb",      8'h13, 1'b0, 1'b0, ex(0,1,1,0,0,1,2'd0,0,1,0,3'd0));
    check("reg_no_err", 32'(bus.mem_err), 32'd0);

    // Direct load with mem_ready never asserted: timeout on MEM cycle WAIT_MAX+1.
    step("dir_fetch",  8'h11, 1'b0, 1'b0, S_FETCH);
    step("dir_decode", 8'h11, 1'b0, 1'b0, '0);
    for (int i = 0; i < WAIT_MAX; i++)
      step("dir_wait", 8'h11, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'd0,1,0,0,3'd0));
    check("dir_err_before", 32'(bus.mem_err), 32'd0);
    step("dir_timeout", 8'h11, 1'b0, 1'b0, ex(0,1,1,0,0,0,2'd0,1,0,0,3'd0));
    check("dir_err_set", 32'(bus.mem_err), 32'd1);
    step("dir_next_fetch", 8'h14, 1'b0, 1'b0, S_FETCH);
    check("dir_err_sticky", 32'(bus.mem_err), 32'd1);

    // Relative load interrupted by reset during its MEM wait.
    step("rel_decode", 8'h14, 1'b0, 1'b0, '0);
    step("rel_wait",   8'h14, 1'b0, 1'b0, ex(0,0,0,0,0,0,2'd3,1,0,0,3'd0));
    reset_n = 1'b0;
    step("rel_in_rst", 8'h14, 1'b0, 1'b1, '0);
    reset_n = 1'b1;
    check("rel_err_cleared", 32'(bus.mem_err), 32'd0);
    step("rel_post_rst_fetch", 8'h1F, 1'b0, 1'b0, S_FETCH);

    // Unrecognised opcode.
    step("bad_decode", 8'h1F, 1'b0, 1'b0, '0);
`ifdef UC_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 8'hA5;
      #1;
      check("bad_trap", 32'(bus.trap), 32'd1);
      step("bad_trap_strobes", 8'hA5, 1'b0, 1'b1, '0);
    end
`else
    step("bad_nop_exec", 8'h1F, 1'b0, 1'b0, ex(0,1,1,0,0,0,2'd0,0,0,0,3'd0));
    step("bad_nop_fetch", 8'hA5, 1'b0, 1'b0, S_FETCH);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
